// File: rtl/serial_arith_pkg.sv
// Shared types and defaults for the bit-serial arithmetic blocks.
package serial_arith_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int SER_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle between a requester and the bit-serial subtractor.
interface serial_subtractor_if
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = SER_WIDTH_DEFAULT
);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow_out;
   logic             overflow;

   modport master (
      output start, a, b,
      input  busy, done, diff, borrow_out, overflow
   );

   modport slave (
      input  start, a, b,
      output busy, done, diff, borrow_out, overflow
   );

endinterface

// File: rtl/Full_sub.sv
// One-bit full subtractor: sub = a - b - c, bo = borrow out.
module Full_sub (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic sub,
   output logic bo
);

   assign sub = a ^ b ^ c;
   assign bo  = (~a & b) | (~(a ^ b) & c);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, through one Full_sub cell with a registered borrow.
module serial_subtractor
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = SER_WIDTH_DEFAULT
)(
   input  logic                clk,
   input  logic                rst,
   serial_subtractor_if.slave  bus
);

   localparam int              CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-2:0] res_sr;
   logic [WIDTH-1:0] res_next;
   logic [CNT_W-1:0] cnt;
   logic             borrow_q;
   logic             a_msb;
   logic             b_msb;
   logic             sub_bit;
   logic             bo_bit;

   Full_sub u_cell (
      .a   (a_sr[0]),
      .b   (b_sr[0]),
      .c   (borrow_q),
      .sub (sub_bit),
      .bo  (bo_bit)
   );

   // res_sr only keeps the upper WIDTH-1 bits; the final bit lands straight in diff.
   assign res_next = {sub_bit, res_sr};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         a_sr           <= '0;
         b_sr           <= '0;
         res_sr         <= '0;
         cnt            <= '0;
         borrow_q       <= 1'b0;
         a_msb          <= 1'b0;
         b_msb          <= 1'b0;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
         bus.diff       <= '0;
         bus.borrow_out <= 1'b0;
         bus.overflow   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               bus.busy <= 1'b0;
               bus.done <= 1'b0;
               if (bus.start) begin
                  a_sr           <= bus.a;
                  b_sr           <= bus.b;
                  a_msb          <= bus.a[WIDTH-1];
                  b_msb          <= bus.b[WIDTH-1];
                  res_sr         <= '0;
                  borrow_q       <= 1'b0;
                  cnt            <= '0;
                  bus.diff       <= '0;
                  bus.borrow_out <= 1'b0;
                  bus.overflow   <= 1'b0;
                  bus.busy       <= 1'b1;
                  state          <= SHIFT;
               end
            end
            SHIFT: begin
               a_sr     <= a_sr >> 1;
               b_sr     <= b_sr >> 1;
               res_sr   <= res_next[WIDTH-1:1];
               borrow_q <= bo_bit;
               cnt      <= cnt + 1'b1;
               if (cnt == LAST) begin
                  bus.diff       <= res_next;
                  bus.borrow_out <= bo_bit;
                  bus.overflow   <= (a_msb != b_msb) && (sub_bit != a_msb);
                  bus.done       <= 1'b1;
                  state          <= DONE;
               end
            end
            DONE: begin
               bus.done <= 1'b0;
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               bus.done <= 1'b0;
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: vector table plus handshake corner cases.
module tb_serial_subtractor;
   import serial_arith_pkg::*;

   localparam int W = 8;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   serial_subtractor_if #(.WIDTH(W)) bus ();

   serial_subtractor #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] diff;
      logic         bo;
      logic         ov;
   } vec_t;

   vec_t vecs [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accepts one operation and waits (bounded) for done; lat counts sampled cycles from accept.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
      @(negedge clk);
      bus.a     = a;
      bus.b     = b;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      lat = 1;
      while (!bus.done && lat < 4 * W) begin
         tick();
         lat++;
      end
   endtask

   initial begin
      int lat;
      int dones;
      int first_done;
      int second_done;

      n_checks = 0;
      n_fail   = 0;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;

      vecs[0] = '{a: 8'd9,   b: 8'd5,   diff: 8'd4,   bo: 1'b0, ov: 1'b0};
      vecs[1] = '{a: 8'd5,   b: 8'd9,   diff: 8'hFC,  bo: 1'b1, ov: 1'b0};
      vecs[2] = '{a: 8'h80,  b: 8'h01,  diff: 8'h7F,  bo: 1'b0, ov: 1'b1};
      vecs[3] = '{a: 8'h00,  b: 8'h00,  diff: 8'h00,  bo: 1'b0, ov: 1'b0};
      vecs[4] = '{a: 8'hFF,  b: 8'hFF,  diff: 8'h00,  bo: 1'b0, ov: 1'b0};

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_done", 32'(bus.done), 32'd0);
      check("reset_diff", 32'(bus.diff), 32'd0);
      check("reset_bo",   32'(bus.borrow_out), 32'd0);
      check("reset_ov",   32'(bus.overflow), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 5; i++) begin
         run_op(vecs[i].a, vecs[i].b, lat);
         check($sformatf("v%0d_latency", i), 32'(lat), 32'(W + 1));
         check($sformatf("v%0d_busy", i), 32'(bus.busy), 32'd1);
         check($sformatf("v%0d_diff", i), 32'(bus.diff), 32'(vecs[i].diff));
         check($sformatf("v%0d_bo", i), 32'(bus.borrow_out), 32'(vecs[i].bo));
         check($sformatf("v%0d_ov", i), 32'(bus.overflow), 32'(vecs[i].ov));
         tick();
         check($sformatf("v%0d_done_pulse", i), 32'(bus.done), 32'd0);
         check($sformatf("v%0d_busy_fall", i), 32'(bus.busy), 32'd0);
         check($sformatf("v%0d_diff_hold", i), 32'(bus.diff), 32'(vecs[i].diff));
      end

      // A second request during SHIFT must be ignored.
      @(negedge clk);
      bus.a = 8'd9; bus.b = 8'd5; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      dones = 0;
      for (int c = 0; c < 2 * W + 4; c++) begin
         if (c == 3) begin
            bus.a = 8'd5; bus.b = 8'd9; bus.start = 1'b1;
         end else begin
            bus.start = 1'b0;
         end
         tick();
         if (bus.done) begin
            dones++;
            check("ignore_diff", 32'(bus.diff), 32'd4);
            check("ignore_bo",   32'(bus.borrow_out), 32'd0);
         end
      end
      bus.start = 1'b0;
      check("ignore_done_count", 32'(dones), 32'd1);
      tick();

      // Held start: done pulses spaced WIDTH+2 cycles.
      @(negedge clk);
      bus.a = 8'd9; bus.b = 8'd5; bus.start = 1'b1;
      first_done  = -1;
      second_done = -1;
      for (int c = 0; c < 4 * W; c++) begin
         tick();
         if (bus.done) begin
            if (first_done < 0) first_done = c;
            else if (second_done < 0) second_done = c;
         end
      end
      bus.start = 1'b0;
      check("b2b_second_seen", 32'(second_done >= 0), 32'd1);
      check("b2b_spacing", 32'(second_done - first_done), 32'(W + 2));
      repeat (2 * W + 4) tick();
      check("b2b_idle_busy", 32'(bus.busy), 32'd0);

      // Asynchronous reset during SHIFT cycle 3.
      @(negedge clk);
      bus.a = 8'd9; bus.b = 8'd5; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      tick();
      check("pre_rst_busy", 32'(bus.busy), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      check("rst_busy",  32'(bus.busy), 32'd0);
      check("rst_done",  32'(bus.done), 32'd0);
      check("rst_diff",  32'(bus.diff), 32'd0);
      check("rst_bo",    32'(bus.borrow_out), 32'd0);
      check("rst_ov",    32'(bus.overflow), 32'd0);
      check("rst_state", 32'(dut.state), 32'(IDLE));
      @(negedge clk);
      rst = 1'b0;
      dones = 0;
      for (int c = 0; c < W + 4; c++) begin
         tick();
         if (bus.done) dones++;
      end
      check("rst_no_done", 32'(dones), 32'd0);
      run_op(8'd9, 8'd5, lat);
      check("post_rst_latency", 32'(lat), 32'(W + 1));
      check("post_rst_diff", 32'(bus.diff), 32'd4);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial WIDTH-bit subtractor computing a − b one bit per clock, LSB first, through a single full-subtractor cell with a registered borrow. It sits directly upstream of the existing Full_sub cell: it sequences operand bits into that cell and collects its sub/bo outputs. The block is a low-area alternative to the ripple subtractor, with a start/busy/done handshake toward the requesting logic.

## Interface
- WIDTH, 8, operand and result width in bits (≥ 2)
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  request; sampled only in IDLE
- a  in  WIDTH  minuend; captured on accepted start
- b  in  WIDTH  subtrahend; captured on accepted start
- busy  out  1  high in SHIFT and DONE
- done  out  1  single-cycle pulse, result valid
- diff  out  WIDTH  a − b mod 2^WIDTH; held until next accepted start
- borrow_out  out  1  final borrow (1 when a < b unsigned)
- overflow  out  1  signed overflow of a − b

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: busy=0, done=0. start=1 at a clock edge loads a_sr←a, b_sr←b, borrow_q←0, cnt←0, and clears diff, borrow_out and overflow to 0. Next state is SHIFT.
- SHIFT: each edge performs the following.
  - Full_sub inputs are a=a_sr[0], b=b_sr[0], c=borrow_q.
  - a_sr and b_sr shift right by one.
  - res_sr shifts right with sub entering at the MSB.
  - borrow_q←bo and cnt←cnt+1.
  - When cnt reaches WIDTH−1 this edge completes the last bit and the next state is DONE.
- DONE entry (same edge as last bit):
  - diff←final res_sr value.
  - borrow_out←final bo.
  - overflow←(a_cap[MSB]≠b_cap[MSB]) && (diff[MSB]≠a_cap[MSB]), using the captured operand MSBs.
- DONE: done=1 for exactly one cycle, busy=1. Next state is IDLE unconditionally.
- start is ignored in SHIFT and DONE; no queuing. start held high continuously gives back-to-back operations with one IDLE cycle between them.
- Operand inputs a and b are don't-care except on the accepting edge.
- cnt width is $clog2(WIDTH). It never wraps, because exit occurs at WIDTH−1.

## Timing
- Reset (async assert, any state): state=IDLE. busy, done, diff, borrow_out, overflow, cnt, borrow_q and all shift regs are 0. Deassertion is assumed synchronous to clk by the system.
- Reset mid-operation aborts it. No done pulse is produced, and the result is lost.
- Latency: start accepted at edge E0, SHIFT active for edges E1..E_WIDTH. done=1 and diff valid in the cycle following E_WIDTH. Total: WIDTH+1 cycles from accept to done.
- busy rises in the cycle after E0 and falls in the cycle after done.
- Throughput: one operation per WIDTH+2 cycles.
- All outputs are registered, with no combinational path from inputs to outputs.

## Structure
- Shared package serial_arith_pkg:
  - State enum state_t {IDLE, SHIFT, DONE}, 2-bit encoding.
  - Default width constant SER_WIDTH_DEFAULT=8.
- Single sub-module: the existing Full_sub cell (ports a, b, c, sub, bo), instantiated once. No other hierarchy.
- Control FSM, counter and shift registers live in serial_subtractor.

## Test plan
- Reset release then a=9, b=5, start pulse. Expect done exactly WIDTH+1 cycles after accept, with diff=4, borrow_out=0, overflow=0.
- a=5, b=9. Expect diff=8'hFC, borrow_out=1, overflow=0.
- a=8'h80, b=8'h01. Expect diff=8'h7F, borrow_out=0, overflow=1.
- a=0, b=0. Expect diff=0, borrow_out=0, overflow=0.
- a=8'hFF, b=8'hFF. Expect diff=0, borrow_out=0, overflow=0.
- Second start with different operands pulsed mid-SHIFT is ignored: first result unchanged and only one done pulse.
- start held high continuously gives consecutive done pulses WIDTH+2 cycles apart.
- rst asserted during SHIFT cycle 3. Expect all outputs 0 immediately with no clock edge, no done pulse, state=IDLE. A subsequent 9−5 still gives diff=4.
